// File: rtl/muldiv_iter_unit_if.sv
// Request/result bundle between the execute stage and the iterative
// multiply/divide unit.
interface muldiv_iter_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] opa_i;
  logic [XLEN-1:0] opb_i;
  logic            annul_i;
  logic            busy_o;
  logic            ready_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, annul_i,
    input  busy_o, ready_o, result_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, annul_i,
    output busy_o, ready_o, result_o
  );
endinterface

// File: rtl/muldiv_iter_unit.sv
// Iterative RV M-extension unit: shift-add multiply and restoring
// divide, one bit per cycle, sharing one 2*XLEN accumulator.
module muldiv_iter_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input logic               clk,
  input logic               rst,
  muldiv_iter_unit_if.slave bus
);

  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2:0]        op_q;
  logic [XLEN-1:0]   b_q;
  logic              neg_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic [XLEN-1:0]   res_q;

  logic            accept;
  logic            last;
  logic            a_sgn, b_sgn;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, div0, ovf, special;
  logic [XLEN-1:0] spec_res;
  logic            neg_in;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   diff;
  logic              ge;
  logic [2*XLEN-1:0] acc_nxt;

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fin_res;

  assign accept = (state_q == IDLE) && bus.start_i && !bus.annul_i;
  assign last   = (cnt_q == CNT_W'(XLEN - 1));

  // Operand decode: signedness, magnitudes and single-cycle corner cases.
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (bus.op_i)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010:  a_sgn = 1'b1;
      default: ;
    endcase
    a_neg  = a_sgn & bus.opa_i[XLEN-1];
    b_neg  = b_sgn & bus.opb_i[XLEN-1];
    a_mag  = a_neg ? -bus.opa_i : bus.opa_i;
    b_mag  = b_neg ? -bus.opb_i : bus.opb_i;
    is_div = bus.op_i[2];
    div0   = is_div && (bus.opb_i == '0);
    ovf    = is_div && !bus.op_i[0] &&
             (bus.opa_i == MIN) && (bus.opb_i == ONES);
    special = div0 || ovf;
    if (div0)
      spec_res = bus.op_i[1] ? bus.opa_i : ONES;
    else
      spec_res = bus.op_i[1] ? '0 : bus.opa_i;
    neg_in = (is_div && bus.op_i[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration: add-and-shift-right or shift-left-and-subtract.
  always_comb begin
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} +
             (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh = acc_q[2*XLEN-1:XLEN-1];
    ge     = rem_sh >= {1'b0, b_q};
    diff   = rem_sh[XLEN-1:0] - b_q;
    if (op_q[2])
      acc_nxt = {ge ? diff : rem_sh[XLEN-1:0],
                 acc_q[XLEN-2:0], ge};
    else
      acc_nxt = {sum, acc_q[XLEN-1:1]};
  end

  // Final sign fix-up and high/low select from the last iteration.
  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[XLEN-1:0];
    rem  = acc_nxt[2*XLEN-1:XLEN];
    if (!op_q[2])
      fin_res = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                     : prod[2*XLEN-1:XLEN];
    else if (op_q[1])
      fin_res = neg_q ? -rem : rem;
    else
      fin_res = neg_q ? -quo : quo;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; annul drops any operation in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = special ? DONE : CALC;
      end
      CALC: begin
        if (bus.annul_i) state_d = IDLE;
        else if (last)   state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: operand latch, iteration and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      res_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.op_i;
            neg_q <= neg_in;
            cnt_q <= '0;
            b_q   <= is_div ? b_mag : a_mag;
            acc_q <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            if (special) begin
              res_q   <= spec_res;
              ready_q <= 1'b1;
            end
          end
        end
        CALC: begin
          if (!bus.annul_i) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              res_q   <= fin_res;
              ready_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o   = (state_q != IDLE);
  assign bus.ready_o  = ready_q;
  assign bus.result_o = res_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Randomised and directed checks of muldiv_iter_unit against an
// arithmetic reference model, for XLEN=32 and XLEN=64.
module tb_muldiv_iter_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_iter_unit_if #(.XLEN(32)) b32 ();
  muldiv_iter_unit_if #(.XLEN(64)) b64 ();

  muldiv_iter_unit #(.XLEN(32)) dut32 (
    .clk(clk),
    .rst(rst),
    .bus(b32)
  );

  muldiv_iter_unit #(.XLEN(64)) dut64 (
    .clk(clk),
    .rst(rst),
    .bus(b64)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_op(input int w,
      input logic [2:0] op, input logic [63:0] ai, input logic [63:0] bi);
    logic [63:0] msk, mn, a, b;
    logic signed [131:0] va, vb, base, p, t, q, r;
    logic sa, sb;
    msk = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    mn  = (w == 64) ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
    a = ai & msk;
    b = bi & msk;
    sa = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) ||
         (op == 3'd4) || (op == 3'd6);
    sb = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    base = '0;
    base[w] = 1'b1;
    va = $signed({68'd0, a});
    vb = $signed({68'd0, b});
    if (sa && ((a & mn) != 0)) va = va - base;
    if (sb && ((b & mn) != 0)) vb = vb - base;
    if (!op[2]) begin
      p = va * vb;
      if (op == 3'd0) return p[63:0] & msk;
      t = p >> w;
      return t[63:0] & msk;
    end
    if (b == 0) return op[1] ? a : msk;
    if (!op[0] && a == mn && b == msk) return op[1] ? 64'd0 : a;
    q = va / vb;
    r = va % vb;
    return op[1] ? (r[63:0] & msk) : (q[63:0] & msk);
  endfunction

  function automatic bit is_special32(input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) ||
           (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Transaction-level model of the 32-bit unit.
  bit          started = 0;
  bit          m_busy = 0, m_ready = 0;
  logic [31:0] m_res = '0, m_pend = '0;
  int          m_rem = 0;

  always @(posedge clk) begin
    logic [63:0] r64;
    started = 1;
    if (rst) begin
      m_busy = 0; m_ready = 0; m_res = '0; m_rem = 0;
    end else begin
      m_ready = 0;
      if (!m_busy) begin
        if (b32.start_i && !b32.annul_i) begin
          r64 = ref_op(32, b32.op_i, {32'd0, b32.opa_i},
                       {32'd0, b32.opb_i});
          m_busy = 1;
          if (is_special32(b32.op_i, b32.opa_i, b32.opb_i)) begin
            m_res = r64[31:0];
            m_ready = 1;
            m_rem = 0;
          end else begin
            m_pend = r64[31:0];
            m_rem = 32;
          end
        end
      end else if (b32.annul_i) begin
        m_busy = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_ready = 1;
          m_res = m_pend;
        end
      end else begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("busy32", {63'd0, b32.busy_o}, {63'd0, m_busy});
      check("ready32", {63'd0, b32.ready_o}, {63'd0, m_ready});
      check("result32", {32'd0, b32.result_o}, {32'd0, m_res});
    end
  end

  task automatic run32(input string nm, input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b,
      input logic [31:0] exp, input int lat, input int poke);
    int got;
    got = -1;
    @(negedge clk);
    b32.start_i = 1'b1;
    b32.op_i = op;
    b32.opa_i = a;
    b32.opb_i = b;
    @(posedge clk);
    #1;
    b32.start_i = 1'b0;
    b32.op_i = 3'($urandom);
    b32.opa_i = $urandom;
    b32.opb_i = $urandom;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      b32.start_i = (c == poke);
      if (c == poke) begin
        b32.op_i = 3'b100;
        b32.opa_i = 32'd1;
        b32.opb_i = 32'd0;
      end
      if (b32.ready_o) begin
        got = c;
        break;
      end
    end
    b32.start_i = 1'b0;
    check({nm, " latency"}, 64'(got), 64'(lat));
    check({nm, " value"}, {32'd0, b32.result_o}, {32'd0, exp});
    @(negedge clk);
  endtask

  task automatic run64(input string nm, input logic [2:0] op,
      input logic [63:0] a, input logic [63:0] b,
      input logic [63:0] exp, input int lat);
    int got;
    got = -1;
    @(negedge clk);
    b64.start_i = 1'b1;
    b64.op_i = op;
    b64.opa_i = a;
    b64.opb_i = b;
    @(posedge clk);
    #1;
    b64.start_i = 1'b0;
    b64.opa_i = {$urandom, $urandom};
    b64.opb_i = {$urandom, $urandom};
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      if (b64.ready_o) begin
        got = c;
        break;
      end
    end
    check({nm, " latency"}, 64'(got), 64'(lat));
    check({nm, " value"}, b64.result_o, exp);
    check({nm, " model"}, ref_op(64, op, a, b), exp);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      4:       return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int got_ready;
    b32.start_i = 0; b32.op_i = 0; b32.opa_i = 0; b32.opb_i = 0;
    b32.annul_i = 0;
    b64.start_i = 0; b64.op_i = 0; b64.opa_i = 0; b64.opb_i = 0;
    b64.annul_i = 0;
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, b32.busy_o}, 64'd0);
    check("reset ready", {63'd0, b32.ready_o}, 64'd0);
    check("reset result", {32'd0, b32.result_o}, 64'd0);
    rst = 1'b0;

    run32("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run32("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, 33, 0);
    run32("MULHU ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 33, 0);
    run32("MULHSU ones", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFF, 33, 0);
    run32("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run32("REM -7%2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run32("DIVU", 3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 0);
    run32("DIV x/0", 3'b100, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run32("REMU 5%0", 3'b111, 32'd5, 32'd0, 32'd5, 1, 0);
    run32("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF,
          32'h8000_0000, 1, 0);
    run32("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run32("MUL zero", 3'b000, 32'd0, 32'd0, 32'd0, 33, 0);
    run32("start while busy", 3'b000, 32'd3, 32'd5, 32'd15, 33, 5);

    // Annul a DIVU in cycle 10; the previous result (15) must remain.
    @(negedge clk);
    b32.start_i = 1; b32.op_i = 3'b101;
    b32.opa_i = 32'd100; b32.opb_i = 32'd7;
    @(posedge clk);
    #1 b32.start_i = 0;
    repeat (10) @(negedge clk);
    b32.annul_i = 1;
    @(posedge clk);
    #1 b32.annul_i = 0;
    @(negedge clk);
    check("annul busy", {63'd0, b32.busy_o}, 64'd0);
    got_ready = 0;
    repeat (40) begin
      @(negedge clk);
      if (b32.ready_o) got_ready++;
    end
    check("annul no ready", 64'(got_ready), 64'd0);
    check("annul result", {32'd0, b32.result_o}, 64'd15);

    // Reset in the middle of a multiply.
    @(negedge clk);
    b32.start_i = 1; b32.op_i = 3'b000;
    b32.opa_i = 32'd9; b32.opb_i = 32'd9;
    @(posedge clk);
    #1 b32.start_i = 0;
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("rst busy", {63'd0, b32.busy_o}, 64'd0);
    check("rst ready", {63'd0, b32.ready_o}, 64'd0);
    check("rst result", {32'd0, b32.result_o}, 64'd0);
    rst = 0;

    // Random traffic: starts, annuls and rare resets at any time.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      b32.start_i = ($urandom_range(0, 3) == 0);
      b32.annul_i = ($urandom_range(0, 59) == 0);
      b32.op_i = 3'($urandom);
      b32.opa_i = pick();
      b32.opb_i = pick();
      rst = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk);
    b32.start_i = 0; b32.annul_i = 0; rst = 0;
    repeat (40) @(negedge clk);

    run64("MULHU64 ones", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run64("DIV64 -1/0", 3'b100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0,
          64'hFFFF_FFFF_FFFF_FFFF, 1);
    run64("MUL64 -3*5", 3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
          64'hFFFF_FFFF_FFFF_FFF1, 65);
    run64("REM64 -7%3", 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3,
          64'hFFFF_FFFF_FFFF_FFFF, 65);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised iterative RISC-V M-extension unit covering MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- One engine: shift-add multiply and restoring divide, one bit per cycle.
- Sits beside the execute stage; the execute stage drives start and holds its stall request until ready_o.
- Replaces the combinational multiplier and the separate divider, and adds spec-compliant corner-case results, annul (flush) support and XLEN scaling.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start_i  input  1  request pulse; sampled only in IDLE.
- op_i  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- opa_i  input  XLEN  rs1 value (multiplicand/dividend).
- opb_i  input  XLEN  rs2 value (multiplier/divisor).
- annul_i  input  1  flush; abort any operation in progress.
- busy_o  output  1  high in CALC and DONE.
- ready_o  output  1  one-cycle pulse; result_o valid.
- result_o  output  XLEN  result; held until the next accepted start.

Behaviour:
- Reset: rst high at a clock edge -> state IDLE, busy_o=0, ready_o=0, result_o=0, counter=0, internal accumulators 0. Applies from any state, including mid-operation.
- States and transitions:
  - IDLE: on start_i & !annul_i, latch op, operands and sign info.
    - Special case -> DONE next cycle.
    - Otherwise -> CALC, counter=0.
  - CALC: one iteration per cycle; after XLEN iterations -> DONE.
  - DONE: ready_o=1 and result_o updated in the same registered cycle; -> IDLE next cycle.
- Latency, start sampled at edge 0:
  - Normal op: ready_o high in cycle XLEN+1 (33 for XLEN=32).
  - Special case: ready_o high in cycle 1.
  - Back-to-back: next start accepted the cycle after DONE.
- start_i while busy_o=1: ignored; no queueing.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: opa signed, opb unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Signed operands are converted to magnitude before iterating; the final result is negated when required.
- Result sign and selection:
  - Product sign = sign(a) XOR sign(b), using signed operands only.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - MUL returns the low XLEN bits of the 2*XLEN product; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide by zero (opb=0), all div ops: quotient = all ones; remainder = opa unchanged. Special case (1-cycle latency).
- Signed overflow (DIV/REM, opa = 1<<(XLEN-1), opb = all ones): quotient = opa; remainder = 0. Special case.
- Multiply has no special cases; operands of 0 still take the full latency.
- Annul:
  - annul_i in CALC or DONE -> IDLE at the next edge.
  - ready_o is not asserted after that edge; result_o keeps its previous value.
  - annul_i and start_i together in IDLE -> start ignored.
  - A ready_o already high in the annul cycle stays high for that cycle; the consumer qualifies it with its own flush.
- Input stability: opa_i, opb_i and op_i are don't-care after the start cycle; all inputs are latched internally.
- Internal width: a 2*XLEN accumulator is shared between product and remainder:quotient. Iterations never overflow it; no truncation except the final high/low select.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3) -> result_o=0xFFFFFFEB, ready_o exactly in cycle 33, busy_o high cycles 1-33.
- High-word multiplies:
  - MULH 0x80000000 * 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide and remainder:
  - DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD.
  - REM -7 % 2 -> 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Corner cases:
  - DIV x/0 -> 0xFFFFFFFF; REMU 5 % 0 -> 5; both with ready_o in cycle 1.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Annul, start-while-busy and reset:
  - DIVU started, annul_i in cycle 10 -> busy_o=0 from cycle 11, no ready_o, result_o unchanged.
  - Start pulsed while busy -> ignored.
  - rst asserted mid-CALC -> all outputs 0 next cycle.
- XLEN=64:
  - MULHU (2^64-1)^2 -> 0xFFFFFFFFFFFFFFFE, ready_o in cycle 65.
  - DIV -1/0 -> all ones in cycle 1.
